// File: rtl/rom_cache_pkg.sv
// rtl/rom_cache_pkg.sv - shared types and address slicing helpers for rom_cache_dm
package rom_cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    FILL
  } state_e;

  localparam int MAX_W = 64;

  // Helpers work on a zero-extended address so any ADDR_W/IDX_W pair can share them.
  function automatic logic [MAX_W-1:0] addr_idx(input logic [MAX_W-1:0] addr, input int idx_w);
    logic [MAX_W-1:0] mask;
    mask = (MAX_W'(1) << idx_w) - MAX_W'(1);
    return addr & mask;
  endfunction

  function automatic logic [MAX_W-1:0] addr_tag(input logic [MAX_W-1:0] addr, input int idx_w);
    return addr >> idx_w;
  endfunction

endpackage

// File: rtl/dual_port_ram.sv
// rtl/dual_port_ram.sv - simple dual-port RAM, port A write, port B registered read
module dual_port_ram #(
  parameter int LEN        = 512,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = $clog2(LEN)
) (
  input  logic                  clk,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic [DATA_WIDTH-1:0] b_rdata
);

  logic [DATA_WIDTH-1:0] mem [LEN];
  logic [DATA_WIDTH-1:0] b_rdata_q;
  logic [DATA_WIDTH-1:0] b_rdata_d;

  always_comb begin
    b_rdata_d = mem[b_addr];
  end

  always_ff @(posedge clk) begin
    if (a_we) begin
      mem[a_addr] <= a_wdata;
    end
    b_rdata_q <= b_rdata_d;
  end

  assign b_rdata = b_rdata_q;

endmodule

// File: rtl/rom_cache_dm.sv
// rtl/rom_cache_dm.sv - direct-mapped read-only cache in front of an SDRAM ROM channel
// Hits answer in two cycles from the tag/data RAM; misses fetch one word and fill the line.
module rom_cache_dm #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 9,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              cache_req,
  input  logic [ADDR_W-1:0] cache_addr,
  output logic              cache_valid,
  output logic [DATA_W-1:0] cache_data,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_valid,
  input  logic [DATA_W-1:0] rom_data,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  import rom_cache_pkg::*;

  localparam int TAG_W  = ADDR_W - IDX_W;
  localparam int LINES  = 1 << IDX_W;
  localparam int LINE_W = TAG_W + DATA_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic              fill_flushed_q, fill_flushed_d;
  logic              cache_valid_q, cache_valid_d;
  logic [DATA_W-1:0] cache_data_q, cache_data_d;
  logic              rom_req_q, rom_req_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [CNT_W-1:0]  hit_count_q, hit_count_d;
  logic [CNT_W-1:0]  miss_count_q, miss_count_d;

  logic [IDX_W-1:0]  req_idx;
  logic [IDX_W-1:0]  idx_r;
  logic [TAG_W-1:0]  tag_r;
  logic [IDX_W-1:0]  rd_idx;
  logic [LINE_W-1:0] ram_rdata;
  logic [TAG_W-1:0]  ram_tag;
  logic [DATA_W-1:0] ram_data;
  logic              ram_we;
  logic              hit;

  assign req_idx  = IDX_W'(addr_idx(MAX_W'(cache_addr), IDX_W));
  assign idx_r    = IDX_W'(addr_idx(MAX_W'(addr_q), IDX_W));
  assign tag_r    = TAG_W'(addr_tag(MAX_W'(addr_q), IDX_W));
  assign ram_tag  = ram_rdata[LINE_W-1:DATA_W];
  assign ram_data = ram_rdata[DATA_W-1:0];

  // In IDLE the RAM is addressed straight from the request so the line is ready in LOOKUP.
  assign rd_idx = (state_q == IDLE) ? req_idx : idx_r;

  dual_port_ram #(
    .LEN        (LINES),
    .DATA_WIDTH (LINE_W)
  ) u_ram (
    .clk     (clk),
    .a_we    (ram_we),
    .a_addr  (idx_r),
    .a_wdata ({tag_r, rom_data}),
    .b_addr  (rd_idx),
    .b_rdata (ram_rdata)
  );

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    valid_d        = valid_q;
    fill_flushed_d = fill_flushed_q;
    cache_valid_d  = 1'b0;
    cache_data_d   = cache_data_q;
    rom_req_d      = rom_req_q;
    rom_addr_d     = rom_addr_q;
    hit_count_d    = hit_count_q;
    miss_count_d   = miss_count_q;
    ram_we         = 1'b0;
    hit            = 1'b0;

    if (flush) begin
      valid_d = '0;
    end

    case (state_q)
      IDLE: begin
        if (cache_req) begin
          addr_d  = cache_addr;
          state_d = LOOKUP;
        end
      end

      LOOKUP: begin
        hit = valid_q[idx_r] && (ram_tag == tag_r) && !flush;
        if (hit) begin
          cache_data_d  = ram_data;
          cache_valid_d = 1'b1;
          if (hit_count_q != {CNT_W{1'b1}}) begin
            hit_count_d = hit_count_q + CNT_W'(1);
          end
          state_d = IDLE;
        end else begin
          rom_req_d      = 1'b1;
          rom_addr_d     = addr_q;
          fill_flushed_d = 1'b0;
          if (miss_count_q != {CNT_W{1'b1}}) begin
            miss_count_d = miss_count_q + CNT_W'(1);
          end
          state_d = FILL;
        end
      end

      FILL: begin
        if (flush) begin
          fill_flushed_d = 1'b1;
        end
        if (rom_valid) begin
          rom_req_d     = 1'b0;
          ram_we        = 1'b1;
          cache_data_d  = rom_data;
          cache_valid_d = 1'b1;
          // A flush seen at any point of this fill keeps the line invalid.
          if (!flush && !fill_flushed_q) begin
            valid_d[idx_r] = 1'b1;
          end
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (reset) begin
      ram_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      valid_q        <= '0;
      fill_flushed_q <= 1'b0;
      cache_valid_q  <= 1'b0;
      cache_data_q   <= '0;
      rom_req_q      <= 1'b0;
      rom_addr_q     <= '0;
      hit_count_q    <= '0;
      miss_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      valid_q        <= valid_d;
      fill_flushed_q <= fill_flushed_d;
      cache_valid_q  <= cache_valid_d;
      cache_data_q   <= cache_data_d;
      rom_req_q      <= rom_req_d;
      rom_addr_q     <= rom_addr_d;
      hit_count_q    <= hit_count_d;
      miss_count_q   <= miss_count_d;
    end
  end

  assign cache_valid = cache_valid_q;
  assign cache_data  = cache_data_q;
  assign rom_req     = rom_req_q;
  assign rom_addr    = rom_addr_q;
  assign hit_count   = hit_count_q;
  assign miss_count  = miss_count_q;

endmodule
